// File: rtl/rv32i_pkg.sv
// Shared RV32I core definitions.
// instr_type_t classifies the instruction sitting in a pipeline stage; the
// hazard unit only cares whether the Execute instruction is a load.
package rv32i_pkg;

    typedef enum logic [2:0] {
        R_TYPE      = 3'd0,
        I_TYPE_ALU  = 3'd1,
        I_TYPE_LOAD = 3'd2,
        S_TYPE      = 3'd3,
        B_TYPE      = 3'd4,
        J_TYPE      = 3'd5,
        U_TYPE      = 3'd6
    } instr_type_t;

    localparam int unsigned DEFAULT_REG_WIDTH = 5;

endpackage

// File: rtl/rv32i_hazard_cmp.sv
// Raw load-use comparison between the Decode sources and the Execute load.
// Ports:
//   regwriteE  - instruction class in Execute
//   Rs1D, Rs2D - source register indices of the Decode instruction
//   RdE        - destination register index of the Execute instruction
//   lwRaw      - Decode reads the register a non-x0 load in Execute writes
module rv32i_hazard_cmp
    import rv32i_pkg::*;
#(
    parameter int REG_WIDTH = DEFAULT_REG_WIDTH
) (
    input  instr_type_t          regwriteE,
    input  logic [REG_WIDTH-1:0] Rs1D,
    input  logic [REG_WIDTH-1:0] Rs2D,
    input  logic [REG_WIDTH-1:0] RdE,
    output logic                 lwRaw
);

    // Plain == comparisons: an X operand yields a non-true result, so the
    // if-style consumers downstream never treat unknown indices as a hazard.
    always_comb begin
        lwRaw = 1'b0;
        if ((regwriteE == I_TYPE_LOAD) && (RdE != '0) &&
            ((Rs1D == RdE) || (Rs2D == RdE))) begin
            lwRaw = 1'b1;
        end
    end

endmodule

// File: rtl/rv32i_hazard_unit.sv
// Hazard control for the 5-stage RV32I pipeline.
// Detects load-use hazards (Decode reads a load result still in Execute) and
// control hazards (branch taken / jump resolved in Execute), and drives the
// stall/flush controls of the Fetch, Decode and Execute pipeline registers.
// Ports:
//   clk, reset       - rising-edge clock, synchronous active-high reset
//   regwriteE        - instruction class in Execute (I_TYPE_LOAD = load)
//   Rs1D, Rs2D       - Decode source register indices
//   RdE, RdM         - Execute / Memory destination indices (RdM unused:
//                      M/W forwarding covers those dependencies)
//   PCSrcE           - branch taken or jump in Execute
//   stallF, stallD   - hold PC and F/D register
//   flushF, flushD   - discard fetched instruction / clear F/D register
//   flushE           - clear D/E register (bubble)
module rv32i_hazard_unit
    import rv32i_pkg::*;
#(
    parameter int REG_WIDTH = DEFAULT_REG_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  instr_type_t          regwriteE,
    input  logic [REG_WIDTH-1:0] Rs1D,
    input  logic [REG_WIDTH-1:0] Rs2D,
    input  logic [REG_WIDTH-1:0] RdE,
    input  logic [REG_WIDTH-1:0] RdM,
    input  logic                 PCSrcE,
    output logic                 stallF,
    output logic                 flushF,
    output logic                 stallD,
    output logic                 flushD,
    output logic                 flushE
);

    logic lwRaw;
    logic lwStall;
    logic stallQ;
    logic unusedRdM;

    // RdM is kept on the interface only; fold it into a sink signal.
    assign unusedRdM = ^RdM;

    rv32i_hazard_cmp #(
        .REG_WIDTH (REG_WIDTH)
    ) uCmp (
        .regwriteE (regwriteE),
        .Rs1D      (Rs1D),
        .Rs2D      (Rs2D),
        .RdE       (RdE),
        .lwRaw     (lwRaw)
    );

    // A load stalls at most once: the cycle after a stall the load has moved
    // on and a bubble sits in Execute, so stallQ suppresses a repeat.
    // A taken branch wins because the Decode instruction is wrong-path anyway.
    assign lwStall = lwRaw && !PCSrcE && !stallQ;

    always_ff @(posedge clk) begin
        if (reset) begin
            stallQ <= 1'b0;
        end else begin
            stallQ <= lwStall;
        end
    end

    // Reset gates every control output combinationally.
    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        flushF = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        if (!reset) begin
            stallF = lwStall;
            stallD = lwStall;
            flushF = PCSrcE;
            flushD = PCSrcE;
            flushE = lwStall | PCSrcE;
        end
    end

endmodule

// File: tb/tb_rv32i_hazard_unit.sv
module tb_rv32i_hazard_unit;
    import rv32i_pkg::*;

    logic        clk;
    logic        reset;
    instr_type_t regwriteE;
    logic [4:0]  Rs1D, Rs2D, RdE, RdM;
    logic        PCSrcE;
    logic        stallF, flushF, stallD, flushD, flushE;

    int passCount  = 0;
    int totalCount = 0;
    logic checkEn = 1'b0;

    rv32i_hazard_unit #(.REG_WIDTH(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .regwriteE (regwriteE),
        .Rs1D      (Rs1D),
        .Rs2D      (Rs2D),
        .RdE       (RdE),
        .RdM       (RdM),
        .PCSrcE    (PCSrcE),
        .stallF    (stallF),
        .flushF    (flushF),
        .stallD    (stallD),
        .flushD    (flushD),
        .flushE    (flushE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output vector order: {stallF, stallD, flushF, flushD, flushE}
    logic [4:0] dutOut;
    assign dutOut = {stallF, stallD, flushF, flushD, flushE};

    // Behavioural model: Decode needs a value a load in Execute has not yet
    // produced -> stall once; a redirect in Execute flushes and overrides.
    logic prevStalled = 1'b0;
    logic [4:0] modelOut;

    function automatic logic [4:0] model(input logic rst, input instr_type_t t,
                                         input logic [4:0] rs1, input logic [4:0] rs2,
                                         input logic [4:0] rdE, input logic br,
                                         input logic prev);
        logic needsLoad;
        logic stall;
        if (rst) return 5'b0;
        needsLoad = (t == I_TYPE_LOAD) && (rdE != 5'd0) && ((rs1 == rdE) || (rs2 == rdE));
        stall = needsLoad && !br && !prev;
        return {stall, stall, br, br, stall | br};
    endfunction

    always_comb modelOut = model(reset, regwriteE, Rs1D, Rs2D, RdE, PCSrcE, prevStalled);

    always @(posedge clk) begin
        prevStalled <= modelOut[4];
        if (reset) checkEn <= 1'b1;
    end

    // Per-cycle model comparison.
    always @(negedge clk) begin
        if (checkEn) begin
            totalCount++;
            if (dutOut === modelOut) passCount++;
            else $display("FAIL model t=%0t got %b expected %b", $time, dutOut, modelOut);
        end
    end

    task automatic step(input string name, input logic rst, input instr_type_t t,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rdE, input logic [4:0] rdM,
                        input logic br, input logic [4:0] expOut);
        @(posedge clk);
        #1;
        reset     = rst;
        regwriteE = t;
        Rs1D      = rs1;
        Rs2D      = rs2;
        RdE       = rdE;
        RdM       = rdM;
        PCSrcE    = br;
        @(negedge clk);
        #1;
        totalCount++;
        if (dutOut === expOut) passCount++;
        else $display("FAIL %s got %b expected %b", name, dutOut, expOut);
    endtask

    initial begin
        reset = 1'b1; regwriteE = R_TYPE;
        Rs1D = 0; Rs2D = 0; RdE = 0; RdM = 0; PCSrcE = 0;

        step("reset0",        1, R_TYPE,      0, 0, 0, 0, 0, 5'b00000);
        step("reset1",        1, R_TYPE,      0, 0, 0, 0, 0, 5'b00000);
        step("branch_match",  0, S_TYPE,      2, 3, 2, 0, 1, 5'b00111);
        step("idle0",         0, R_TYPE,      1, 1, 0, 0, 0, 5'b00000);
        step("loaduse_c1",    0, I_TYPE_LOAD, 2, 3, 2, 0, 0, 5'b11001);
        step("loaduse_c2",    0, I_TYPE_LOAD, 2, 3, 2, 0, 0, 5'b00000);
        step("loaduse_c3",    0, I_TYPE_LOAD, 2, 3, 2, 0, 0, 5'b11001);
        step("loaduse_c4",    0, I_TYPE_LOAD, 2, 3, 2, 0, 0, 5'b00000);
        step("dep_on_M_only", 0, I_TYPE_LOAD, 5, 3, 2, 5, 0, 5'b00000);
        step("load_branch",   0, I_TYPE_LOAD, 6, 6, 6, 0, 1, 5'b00111);
        step("after_ld_br",   0, I_TYPE_LOAD, 6, 6, 6, 0, 0, 5'b11001);
        step("idle1",         0, R_TYPE,      0, 0, 0, 0, 0, 5'b00000);
        step("x0_load",       0, I_TYPE_LOAD, 0, 0, 0, 0, 0, 5'b00000);
        step("store_match",   0, S_TYPE,      2, 2, 2, 0, 0, 5'b00000);
        step("rs2_hazard",    0, I_TYPE_LOAD, 7, 9, 9, 0, 0, 5'b11001);
        step("idle2",         0, R_TYPE,      0, 0, 0, 0, 0, 5'b00000);
        step("pre_reset_ld",  0, I_TYPE_LOAD, 2, 3, 2, 0, 0, 5'b11001);
        step("mid_reset1",    1, I_TYPE_LOAD, 2, 3, 2, 0, 0, 5'b00000);
        step("mid_reset2",    1, I_TYPE_LOAD, 2, 3, 2, 0, 0, 5'b00000);
        step("post_reset",    0, I_TYPE_LOAD, 2, 3, 2, 0, 0, 5'b11001);
        step("post_reset2",   0, I_TYPE_LOAD, 2, 3, 2, 0, 0, 5'b00000);

        @(posedge clk);
        #2;
        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule

// File: doc/rv32i_hazard_unit.md
# rv32i_hazard_unit

Pipeline hazard-control block for the 5-stage RV32I core (F/D/E/M/W). It detects load-use data hazards between the instruction in Decode and a load in Execute, and control hazards from taken branches and jumps resolved in Execute. It drives the stall and flush controls of the Fetch, Decode and Execute pipeline registers. Forwarding is handled elsewhere.

## Interface
- REG_WIDTH, default 5: register-index width.
- clk  input  1: rising-edge clock.
- reset  input  1: synchronous, active-high reset.
- regwriteE  input  instr_type_t: instruction class currently in Execute. I_TYPE_LOAD marks a load.
- Rs1D  input  REG_WIDTH: rs1 index of the Decode instruction.
- Rs2D  input  REG_WIDTH: rs2 index of the Decode instruction.
- RdE  input  REG_WIDTH: rd index of the Execute instruction.
- RdM  input  REG_WIDTH: rd index of the Memory instruction. Not used for stalling, because M/W forwarding resolves those dependencies. The port is kept for interface stability.
- PCSrcE  input  1: branch taken or jump in Execute.
- stallF  output  1: hold the PC / Fetch register.
- flushF  output  1: invalidate the instruction fetched this cycle.
- stallD  output  1: hold the F/D register.
- flushD  output  1: clear the F/D register (insert a bubble).
- flushE  output  1: clear the D/E register (insert a bubble).

## Operation
- Raw load-use hazard:
  - lw_raw = (regwriteE == I_TYPE_LOAD) && (RdE != 0) && ((Rs1D == RdE) || (Rs2D == RdE)).
  - Any other regwriteE value, including S_TYPE, never stalls.
- One-shot qualification: lw_stall = lw_raw && !PCSrcE && !stall_q.
  - stall_q is a 1-bit register that captures lw_stall each cycle.
  - A load produces at most one stall cycle. In the real pipeline the following cycle has a bubble in E.
  - If the inputs are held constant, lw_stall alternates 1,0,1,0…; this is required behaviour.
- Outputs, when reset is low:
  - stallF = stallD = lw_stall.
  - flushF = PCSrcE.
  - flushD = PCSrcE.
  - flushE = lw_stall | PCSrcE.
- Priority: PCSrcE beats a load-use hazard. With both present, stalls are 0 and flushF, flushD and flushE are 1. The wrong-path instruction in D is discarded, so stalling it is pointless.
- Register x0 never creates a hazard, since RdE == 0 is excluded.

## Timing
- All outputs are combinational from the inputs and stall_q; there is no added latency.
- stall_q updates on the rising edge of clk.
- Reset (synchronous, active-high):
  - At the first rising edge with reset high, stall_q clears to 0.
  - While reset is high, all five outputs are forced to 0 combinationally.
  - After reset deasserts, the first cycle's outputs follow the rules above with stall_q = 0.
- Reset asserted mid-stall: the outputs drop to 0 immediately and stall_q is 0 after the next edge. No stall is carried over the reset.
- Inputs must be stable before the clock edge. Undefined (X) inputs must not be resolved as hazards; compare with ==, treating X as not matching in synthesis.

## Structure
- instr_type_t (with S_TYPE, I_TYPE_LOAD, R_TYPE, I_TYPE_ALU, B_TYPE, J_TYPE, U_TYPE, …) lives in rv32i_pkg. The block imports it and declares no enum of its own.
- Optional combinational sub-module: rv32i_hazard_cmp computes the lw_raw comparison.
- The top level holds the stall_q register, the priority logic and the reset gating.

## Test plan
- Taken branch with a matching register: regwriteE=S_TYPE, Rs1D=2, Rs2D=3, RdE=2, PCSrcE=1 -> stallF=stallD=0, flushF=flushD=flushE=1.
- Load-use hazard: regwriteE=I_TYPE_LOAD, Rs1D=2, Rs2D=3, RdE=2, PCSrcE=0, held for 4 cycles.
  - Cycle 1: stallF=stallD=flushE=1, flushD=0.
  - Cycle 2: all outputs 0.
  - Cycles 3 and 4 repeat the cycle 1/2 pattern.
- Dependency only on M: regwriteE=I_TYPE_LOAD, Rs1D=5, Rs2D=3, RdE=2, RdM=5, PCSrcE=0 -> all outputs 0.
- Load-use hazard plus taken branch: regwriteE=I_TYPE_LOAD, Rs1D=Rs2D=RdE=6, PCSrcE=1 -> stalls 0, flushF=flushD=flushE=1, stall_q stays 0.
- x0 and non-load cases:
  - regwriteE=I_TYPE_LOAD, Rs1D=0, RdE=0, PCSrcE=0 -> no stall.
  - regwriteE=S_TYPE, Rs1D=Rs2D=RdE=2, PCSrcE=0 -> no stall.
- Reset mid-stall: apply the load-use hazard, then assert reset for 2 cycles.
  - While reset is high, all outputs are 0.
  - In the first cycle after release, with the same inputs, stallF=stallD=flushE=1.
